// File: rtl/ste_snd_pkg.sv
// Shared constants and types for the STE sound-path LMC1992 emulation:
// Microwire frame fields, setting limits, gain table and scheduler states.
package ste_snd_pkg;

  localparam logic [1:0] LMC_ADDR = 2'b10;

  typedef enum logic [2:0] {
    CMD_MIX    = 3'd0,
    CMD_BASS   = 3'd1,
    CMD_TREBLE = 3'd2,
    CMD_MASTER = 3'd3,
    CMD_RVOL   = 3'd4,
    CMD_LVOL   = 3'd5,
    CMD_RSV6   = 3'd6,
    CMD_RSV7   = 3'd7
  } cmd_e;

  localparam logic [5:0] MAX_MASTER = 6'd40;
  localparam logic [4:0] MAX_SIDE   = 5'd20;
  localparam logic [3:0] MAX_TONE   = 4'd12;
  localparam logic [3:0] TONE_FLAT  = 4'd6;

  // Q8 gains for 0, -2 and -4 dB; each further -6 dB is one right shift.
  localparam logic [8:0] G3_0 = 9'd256;
  localparam logic [8:0] G3_1 = 9'd203;
  localparam logic [8:0] G3_2 = 9'd161;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL_L = 2'd1,
    ST_MUL_R = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [4:0] q;
    logic [1:0] r;
  } divmod3_t;

  function automatic divmod3_t divmod3(input logic [5:0] idx);
    divmod3_t d;
    d.q = 5'(idx / 6'd3);
    d.r = 2'(idx % 6'd3);
    return d;
  endfunction

  function automatic logic [7:0] sat8(input logic signed [17:0] p);
    logic signed [17:0] v;
    v = (p >>> 8) + 18'sd128;
    if (v < 18'sd0)        return 8'd0;
    else if (v > 18'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

endpackage

// File: rtl/lmc1992_mw_rx.sv
// Microwire receiver: collects masked bits into an 11-bit frame, validates it
// on the transfer-end pulse and updates the LMC1992 setting registers.
module lmc1992_mw_rx
  import ste_snd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_mw_strobe,
  input  logic       i_mw_clk,
  input  logic       i_mw_data,
  input  logic       i_mw_done,
  output logic [1:0] o_mix,
  output logic [3:0] o_bass,
  output logic [3:0] o_treble,
  output logic [5:0] o_master,
  output logic [4:0] o_left,
  output logic [4:0] o_right,
  output logic       o_cmd_err
);

  logic [10:0] r_sr;
  logic [3:0]  r_cnt;
  logic [10:0] w_sr_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [1:0]  w_addr;
  cmd_e        w_cmd;
  logic [5:0]  w_data;
  logic        w_accept;

  // A bit arriving with mw_done is shifted in before the frame is checked.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sr_nxt  = r_sr;
    w_cnt_nxt = r_cnt;
    if (i_mw_strobe && i_mw_clk) begin
      w_sr_nxt = {r_sr[9:0], i_mw_data};
      if (r_cnt != 4'd15) w_cnt_nxt = r_cnt + 4'd1;
    end
  end

  assign w_addr   = w_sr_nxt[10:9];
  assign w_cmd    = cmd_e'(w_sr_nxt[8:6]);
  assign w_data   = w_sr_nxt[5:0];
  assign w_accept = (w_cnt_nxt >= 4'd11) && (w_addr == LMC_ADDR);

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr      <= '0;
      r_cnt     <= '0;
      o_mix     <= 2'b01;
      o_bass    <= TONE_FLAT;
      o_treble  <= TONE_FLAT;
      o_master  <= MAX_MASTER;
      o_left    <= MAX_SIDE;
      o_right   <= MAX_SIDE;
      o_cmd_err <= 1'b0;
    end else begin
      r_sr      <= w_sr_nxt;
      r_cnt     <= i_mw_done ? 4'd0 : w_cnt_nxt;
      o_cmd_err <= i_mw_done && !w_accept;
      if (i_mw_done && w_accept) begin
        case (w_cmd)
          CMD_MIX:    o_mix    <= w_data[1:0];
          CMD_BASS:   o_bass   <= (w_data[3:0] > MAX_TONE) ? MAX_TONE : w_data[3:0];
          CMD_TREBLE: o_treble <= (w_data[3:0] > MAX_TONE) ? MAX_TONE : w_data[3:0];
          CMD_MASTER: o_master <= (w_data > MAX_MASTER) ? MAX_MASTER : w_data;
          CMD_RVOL:   o_right  <= (w_data[4:0] > MAX_SIDE) ? MAX_SIDE : w_data[4:0];
          CMD_LVOL:   o_left   <= (w_data[4:0] > MAX_SIDE) ? MAX_SIDE : w_data[4:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ste_lmc1992.sv
// LMC1992 volume/tone front end for STE DMA sound: Microwire command decode
// plus master/side attenuation through one multiplier shared by L and R.
module ste_lmc1992
  import ste_snd_pkg::*;
#(
  parameter int GAIN_W = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mw_strobe,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_done,
  input  logic       sample_en,
  input  logic [7:0] audio_l_in,
  input  logic [7:0] audio_r_in,
  output logic [7:0] audio_l,
  output logic [7:0] audio_r,
  output logic       audio_valid,
  output logic [1:0] mix,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic       cmd_err
);

  logic [5:0] w_master;
  logic [4:0] w_left;
  logic [4:0] w_right;

  lmc1992_mw_rx u_rx (
    .clk        (clk),
    .reset      (reset),
    .i_mw_strobe(mw_strobe),
    .i_mw_clk   (mw_clk),
    .i_mw_data  (mw_data),
    .i_mw_done  (mw_done),
    .o_mix      (mix),
    .o_bass     (bass),
    .o_treble   (treble),
    .o_master   (w_master),
    .o_left     (w_left),
    .o_right    (w_right),
    .o_cmd_err  (cmd_err)
  );

  function automatic logic [GAIN_W-1:0] gain_of(input logic [5:0] idx);
    divmod3_t   d;
    logic [8:0] g;
    d = divmod3(idx);
    case (d.r)
      2'd0:    g = G3_0;
      2'd1:    g = G3_1;
      default: g = G3_2;
    endcase
    return GAIN_W'(g >> d.q);
  endfunction

  logic [5:0]        w_idx_l;
  logic [5:0]        w_idx_r;
  assign w_idx_l = (MAX_MASTER - w_master) + (6'(MAX_SIDE) - 6'(w_left));
  assign w_idx_r = (MAX_MASTER - w_master) + (6'(MAX_SIDE) - 6'(w_right));

  state_e                   r_state;
  logic signed [8:0]        r_s_l;
  logic signed [8:0]        r_s_r;
  logic [GAIN_W-1:0]        r_gain_l;
  logic [GAIN_W-1:0]        r_gain_r;
  logic signed [17:0]       r_p_l;

  // Shared multiplier: the operand mux follows the scheduler state.
  logic signed [17:0] w_mul_a;
  logic signed [17:0] w_mul_b;
  logic signed [17:0] w_prod;
  assign w_mul_a = (r_state == ST_MUL_L) ? {{9{r_s_l[8]}}, r_s_l} : {{9{r_s_r[8]}}, r_s_r};
  assign w_mul_b = (r_state == ST_MUL_L) ? {{(18-GAIN_W){1'b0}}, r_gain_l}
                                         : {{(18-GAIN_W){1'b0}}, r_gain_r};
  assign w_prod  = w_mul_a * w_mul_b;

  // The right product is saturated straight into the output register so both
  // channels land together on the edge into OUT, three cycles after sample_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_s_l       <= '0;
      r_s_r       <= '0;
      r_gain_l    <= '0;
      r_gain_r    <= '0;
      r_p_l       <= '0;
      audio_l     <= 8'd128;
      audio_r     <= 8'd128;
      audio_valid <= 1'b0;
    end else begin
      audio_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (sample_en) begin
            r_s_l    <= {~audio_l_in[7], ~audio_l_in[7], audio_l_in[6:0]};
            r_s_r    <= {~audio_r_in[7], ~audio_r_in[7], audio_r_in[6:0]};
            r_gain_l <= gain_of(w_idx_l);
            r_gain_r <= gain_of(w_idx_r);
            r_state  <= ST_MUL_L;
          end
        end
        ST_MUL_L: begin
          r_p_l   <= w_prod;
          r_state <= ST_MUL_R;
        end
        ST_MUL_R: begin
          audio_l     <= sat8(r_p_l);
          audio_r     <= sat8(w_prod);
          audio_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ste_lmc1992.sv
// Directed bench for ste_lmc1992: Microwire command frames plus audio samples,
// with a scoreboard queue checked by an independent output monitor.
module tb_ste_lmc1992;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mw_strobe = 1'b0;
  logic       mw_clk = 1'b0;
  logic       mw_data = 1'b0;
  logic       mw_done = 1'b0;
  logic       sample_en = 1'b0;
  logic [7:0] audio_l_in = 8'd128;
  logic [7:0] audio_r_in = 8'd128;
  logic [7:0] audio_l;
  logic [7:0] audio_r;
  logic       audio_valid;
  logic [1:0] mix;
  logic [3:0] bass;
  logic [3:0] treble;
  logic       cmd_err;

  ste_lmc1992 #(.GAIN_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .mw_strobe  (mw_strobe),
    .mw_clk     (mw_clk),
    .mw_data    (mw_data),
    .mw_done    (mw_done),
    .sample_en  (sample_en),
    .audio_l_in (audio_l_in),
    .audio_r_in (audio_r_in),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .audio_valid(audio_valid),
    .mix        (mix),
    .bass       (bass),
    .treble     (treble),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] l;
    logic [7:0] r;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_valid = 0;
  int   n_err   = 0;
  int   exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every audio_valid pops one expected pair.
  always @(negedge clk) begin
    if (cmd_err) n_err++;
    if (audio_valid) begin
      n_valid++;
      if (sb.size() == 0) begin
        check("unexpected_audio_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("audio_l", {24'd0, audio_l}, {24'd0, e.l});
        check("audio_r", {24'd0, audio_r}, {24'd0, e.r});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Sends a 16-bit transfer MSB first; optionally the last bit shares the
  // cycle with mw_done.
  task automatic send_frame(input logic [15:0] bits, input logic [15:0] mask,
                            input bit last_with_done);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      mw_strobe = 1'b1;
      mw_clk    = mask[i];
      mw_data   = bits[i];
      mw_done   = (i == 0) && last_with_done;
    end
    if (!last_with_done) begin
      @(negedge clk);
      mw_strobe = 1'b0;
      mw_clk    = 1'b0;
      mw_data   = 1'b0;
      mw_done   = 1'b1;
    end
    @(negedge clk);
    mw_strobe = 1'b0;
    mw_clk    = 1'b0;
    mw_data   = 1'b0;
    mw_done   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      check("scoreboard_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic send_sample(input logic [7:0] l, input logic [7:0] r,
                             input logic [7:0] el, input logic [7:0] er);
    exp_t e;
    e.l = el;
    e.r = er;
    @(negedge clk);
    sb.push_back(e);
    audio_l_in = l;
    audio_r_in = r;
    sample_en  = 1'b1;
    @(negedge clk);
    sample_en  = 1'b0;
    wait_drain();
  endtask

  initial begin
    logic [11:0] pattern;
    int          valid_before;
    exp_t        e;

    do_reset();
    check("rst_audio_l", {24'd0, audio_l}, 32'd128);
    check("rst_audio_r", {24'd0, audio_r}, 32'd128);
    check("rst_valid", {31'd0, audio_valid}, 32'd0);
    check("rst_mix", {30'd0, mix}, 32'd1);
    check("rst_bass", {28'd0, bass}, 32'd6);
    check("rst_treble", {28'd0, treble}, 32'd6);
    check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);

    // Reset gains are 0 dB: full-scale passthrough both ways.
    send_sample(8'd255, 8'd0, 8'd255, 8'd0);

    // master = 0 -> idx 40, gain 0.
    send_frame(16'h04C0, 16'h07FF, 1'b0);
    send_sample(8'd255, 8'd255, 8'd128, 8'd128);

    // Left = 17 -> idx 3 -> gain 128; right still 0 dB.
    do_reset();
    send_frame(16'h0551, 16'h07FF, 1'b0);
    send_sample(8'd228, 8'd228, 8'd178, 8'd228);
    send_sample(8'd28, 8'd128, 8'd78, 8'd128);

    // Wrong address: discarded, master stays at 40.
    send_frame(16'h02C0, 16'h07FF, 1'b0);
    exp_err++;
    check("err_wrong_addr", n_err, exp_err);
    send_sample(8'd255, 8'd255, 8'd191, 8'd255);

    // Only 10 valid bits: discarded.
    send_frame(16'h04C0, 16'h03FF, 1'b0);
    exp_err++;
    check("err_short_frame", n_err, exp_err);
    send_sample(8'd255, 8'd255, 8'd191, 8'd255);

    // 13 valid bits, last 11 = 10 001 000011.
    send_frame(16'h1C43, 16'h1FFF, 1'b0);
    check("bass_13bit", {28'd0, bass}, 32'd3);
    check("no_err_13bit", n_err, exp_err);

    // Bass clamp 15 -> 12.
    send_frame(16'h044F, 16'h07FF, 1'b0);
    check("bass_clamp", {28'd0, bass}, 32'd12);

    // Treble 5 with the final bit coincident with mw_done.
    send_frame(16'h0485, 16'h07FF, 1'b1);
    check("treble_simul", {28'd0, treble}, 32'd5);

    send_frame(16'h0402, 16'h07FF, 1'b0);
    check("mix_set", {30'd0, mix}, 32'd2);

    // Command 110 is ignored silently.
    send_frame(16'h0580, 16'h07FF, 1'b0);
    check("cmd6_no_err", n_err, exp_err);
    check("cmd6_mix_kept", {30'd0, mix}, 32'd2);

    // Right = 10 -> idx 10 -> gain 203>>3 = 25.
    send_frame(16'h050A, 16'h07FF, 1'b0);
    send_sample(8'd0, 8'd255, 8'd64, 8'd140);
    send_sample(8'd228, 8'd0, 8'd178, 8'd115);

    // sample_en held high: one accepted sample per 4 cycles.
    e.l = 8'd178;
    e.r = 8'd137;
    repeat (3) sb.push_back(e);
    pattern = '0;
    @(negedge clk);
    audio_l_in = 8'd228;
    audio_r_in = 8'd228;
    sample_en  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      pattern[k-1] = audio_valid;
    end
    sample_en = 1'b0;
    check("throughput_pattern", {20'd0, pattern}, 32'h444);
    wait_drain();
    repeat (4) @(negedge clk);

    // Reset asserted while the scheduler is in MUL_R.
    valid_before = n_valid;
    audio_l_in = 8'd0;
    audio_r_in = 8'd0;
    sample_en  = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_midflight_no_valid", n_valid, valid_before);
    check("rst_midflight_l", {24'd0, audio_l}, 32'd128);
    check("rst_midflight_r", {24'd0, audio_r}, 32'd128);
    check("rst_midflight_mix", {30'd0, mix}, 32'd1);
    check("rst_midflight_bass", {28'd0, bass}, 32'd6);
    send_sample(8'd255, 8'd0, 8'd255, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
